// File: rtl/mor1kx_pcu_event_gen_pkg.sv
// Shared constants and helpers for the PCU event-conditioning stage.
// Optional stall run filter: OR1K_PCU_STALL_FILTER_EN.
package mor1kx_pcu_event_gen_pkg;

  localparam int PCU_EDGE_SRCS       = 5;
  localparam int PCU_DEF_STALL_MIN   = 4;
  localparam int PCU_DEF_STALL_CNT_W = 3;

  function automatic logic [PCU_EDGE_SRCS-1:0] pcu_rise(
    input logic [PCU_EDGE_SRCS-1:0] lvl,
    input logic [PCU_EDGE_SRCS-1:0] prev
  );
    return lvl & ~prev;
  endfunction

endpackage

// File: rtl/mor1kx_pcu_stall_filter.sv
// Turns one stall level into registered per-cycle count pulses.
// With OR1K_PCU_STALL_FILTER_EN, only runs of STALL_MIN_CYCLES or more count.
module mor1kx_pcu_stall_filter
  import mor1kx_pcu_event_gen_pkg::*;
#(
  parameter int STALL_MIN_CYCLES = PCU_DEF_STALL_MIN,
  parameter int STALL_CNT_WIDTH  = PCU_DEF_STALL_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic du_stall,
  input  logic level,
  output logic pulse
);

`ifdef OR1K_PCU_STALL_FILTER_EN
  localparam logic [STALL_CNT_WIDTH-1:0] SAT =
    STALL_CNT_WIDTH'(STALL_MIN_CYCLES - 1);

  logic [STALL_CNT_WIDTH-1:0] cnt;

  // Counter saturates at SAT so long stalls keep pulsing every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (du_stall || !level) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      if (cnt != SAT)
        cnt <= cnt + 1'b1;
      pulse <= (cnt == SAT);
    end
  end
`else
  logic [63:0] unused_cfg;
  assign unused_cfg = {32'(STALL_MIN_CYCLES), 32'(STALL_CNT_WIDTH)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pulse <= 1'b0;
    else
      pulse <= level & ~du_stall;
  end
`endif

endmodule

// File: rtl/mor1kx_pcu_event_gen.sv
// Conditions raw pipeline/cache/MMU status into registered PCU event pulses.
// Optional stall run filter selected by OR1K_PCU_STALL_FILTER_EN.
module mor1kx_pcu_event_gen
  import mor1kx_pcu_event_gen_pkg::*;
#(
  parameter int STALL_MIN_CYCLES = PCU_DEF_STALL_MIN,
  parameter int STALL_CNT_WIDTH  = PCU_DEF_STALL_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic du_stall_i,
  input  logic spr_sys_mode_i,
  input  logic lsu_load_ack_i,
  input  logic lsu_store_ack_i,
  input  logic fetch_valid_i,
  input  logic padv_decode_i,
  input  logic dc_refill_i,
  input  logic ic_refill_i,
  input  logic dmmu_tlb_miss_i,
  input  logic immu_tlb_miss_i,
  input  logic fetch_stall_i,
  input  logic lsu_stall_i,
  input  logic datadep_stall_i,
  input  logic branch_mispredict_i,
  output logic pcu_sys_mode_o,
  output logic pcu_event_load_o,
  output logic pcu_event_store_o,
  output logic pcu_event_ifetch_o,
  output logic pcu_event_dcache_miss_o,
  output logic pcu_event_icache_miss_o,
  output logic pcu_event_ifetch_stall_o,
  output logic pcu_event_lsu_stall_o,
  output logic pcu_event_brn_stall_o,
  output logic pcu_event_dtlb_miss_o,
  output logic pcu_event_itlb_miss_o,
  output logic pcu_event_datadep_stall_o
);

  logic [PCU_EDGE_SRCS-1:0] lvl;
  logic [PCU_EDGE_SRCS-1:0] prev;
  logic [PCU_EDGE_SRCS-1:0] rise;

  assign lvl = {dc_refill_i, ic_refill_i, dmmu_tlb_miss_i,
                immu_tlb_miss_i, branch_mispredict_i};
  assign rise = pcu_rise(lvl, prev);

  // History tracks levels even under debug stall, so a level
  // that rose while masked is already seen when the mask drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prev <= '0;
    else
      prev <= lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcu_sys_mode_o          <= 1'b0;
      pcu_event_load_o        <= 1'b0;
      pcu_event_store_o       <= 1'b0;
      pcu_event_ifetch_o      <= 1'b0;
      pcu_event_dcache_miss_o <= 1'b0;
      pcu_event_icache_miss_o <= 1'b0;
      pcu_event_dtlb_miss_o   <= 1'b0;
      pcu_event_itlb_miss_o   <= 1'b0;
      pcu_event_brn_stall_o   <= 1'b0;
    end else begin
      pcu_sys_mode_o          <= spr_sys_mode_i;
      pcu_event_load_o        <= lsu_load_ack_i & ~du_stall_i;
      pcu_event_store_o       <= lsu_store_ack_i & ~du_stall_i;
      pcu_event_ifetch_o      <= fetch_valid_i & padv_decode_i &
                                 ~du_stall_i;
      pcu_event_dcache_miss_o <= rise[4] & ~du_stall_i;
      pcu_event_icache_miss_o <= rise[3] & ~du_stall_i;
      pcu_event_dtlb_miss_o   <= rise[2] & ~du_stall_i;
      pcu_event_itlb_miss_o   <= rise[1] & ~du_stall_i;
      pcu_event_brn_stall_o   <= rise[0] & ~du_stall_i;
    end
  end

  mor1kx_pcu_stall_filter #(
    .STALL_MIN_CYCLES(STALL_MIN_CYCLES),
    .STALL_CNT_WIDTH (STALL_CNT_WIDTH)
  ) u_fetch_stall (
    .clk     (clk),
    .rst_n   (rst_n),
    .du_stall(du_stall_i),
    .level   (fetch_stall_i),
    .pulse   (pcu_event_ifetch_stall_o)
  );

  mor1kx_pcu_stall_filter #(
    .STALL_MIN_CYCLES(STALL_MIN_CYCLES),
    .STALL_CNT_WIDTH (STALL_CNT_WIDTH)
  ) u_lsu_stall (
    .clk     (clk),
    .rst_n   (rst_n),
    .du_stall(du_stall_i),
    .level   (lsu_stall_i),
    .pulse   (pcu_event_lsu_stall_o)
  );

  mor1kx_pcu_stall_filter #(
    .STALL_MIN_CYCLES(STALL_MIN_CYCLES),
    .STALL_CNT_WIDTH (STALL_CNT_WIDTH)
  ) u_datadep_stall (
    .clk     (clk),
    .rst_n   (rst_n),
    .du_stall(du_stall_i),
    .level   (datadep_stall_i),
    .pulse   (pcu_event_datadep_stall_o)
  );

endmodule
